// File: rtl/bus_initiator.sv
// bus_initiator: runs single read/write requests from the core-side port on the
// shared peripheral bus, completing on fc_bus from the addressed device. Requests
// that are misaligned or use the reserved size never reach the bus, and an access
// that sees no fc_bus within TIMEOUT_CYCLES bus cycles is aborted with err.
module bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] addr_bus,
   inout  wire  [31:0] data_bus,
   output logic        rd_bus,
   output logic        wr_bus,
   output logic [3:0]  data_mask_bus,
   input  logic        fc_bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   // The counter holds the number of fc-less edges seen so far, so the access
   // is abandoned on the edge where one more miss would reach the limit.
   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [31:0] wdata_q;
   logic [15:0] timeout_cnt;
   logic        req_bad;
   logic [3:0]  req_mask;

   // Byte enables for a request size; the reserved size never reaches the bus.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      logic [3:0] m;
      m = 4'b1111;
      case (size)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Widen each byte enable to a full byte lane of the data bus.
   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   // Classify the incoming request: reserved size or an address that is not a
   // multiple of the access size is rejected without touching the bus.
   always_comb begin
      req_bad  = 1'b0;
      req_mask = size_mask(req_size);
      case (req_size)
         2'd0:    req_bad = 1'b0;
         2'd1:    req_bad = req_addr[0];
         2'd2:    req_bad = (req_addr[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
   end

   // Write data is only put on the shared bus while a write strobe is active;
   // the strobe register resets asynchronously, so reset releases the bus at once.
   assign data_bus = wr_bus ? wdata_q : 'z;

   // Transaction sequencer with all bus and status outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wdata_q       <= '0;
         timeout_cnt   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         rdata         <= '0;
         addr_bus      <= '0;
         rd_bus        <= 1'b0;
         wr_bus        <= 1'b0;
         data_mask_bus <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req) begin
                  wdata_q     <= req_wdata;
                  timeout_cnt <= '0;
                  busy        <= 1'b1;
                  if (req_bad) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state         <= ACCESS;
                     addr_bus      <= req_addr;
                     data_mask_bus <= req_mask;
                     rd_bus        <= ~req_wr;
                     wr_bus        <= req_wr;
                  end
               end
            end

            ACCESS: begin
               if (fc_bus == 1'b1) begin
                  if (rd_bus) begin
                     rdata <= data_bus & lane_mask(data_mask_bus);
                  end
                  state         <= DONE;
                  done          <= 1'b1;
                  err           <= 1'b0;
                  addr_bus      <= '0;
                  rd_bus        <= 1'b0;
                  wr_bus        <= 1'b0;
                  data_mask_bus <= '0;
               end else if (timeout_cnt == LAST_COUNT) begin
                  state         <= DONE;
                  done          <= 1'b1;
                  err           <= 1'b1;
                  addr_bus      <= '0;
                  rd_bus        <= 1'b0;
                  wr_bus        <= 1'b0;
                  data_mask_bus <= '0;
               end else begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
            end

            default: begin
               state         <= IDLE;
               busy          <= 1'b0;
               done          <= 1'b0;
               err           <= 1'b0;
               addr_bus      <= '0;
               rd_bus        <= 1'b0;
               wr_bus        <= 1'b0;
               data_mask_bus <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Bus initiator (master) for the on-chip peripheral bus: accepts single read/write requests from a core-side port and runs them on the shared bus (addr_bus/data_bus/rd_bus/wr_bus/data_mask_bus), completing on fc_bus from the addressed device. It is the counterpart of the device-side bus interfaces and sits between the CPU load/store unit and the peripheral bus. It also checks alignment and detects timeouts when no device responds.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles to wait for fc_bus before aborting with error; legal range 1..65535.

- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  1  request strobe, sampled while busy=0
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_wdata  input  32  write data, right-justified (bits [7:0] = byte at req_addr)
- busy  output  1  transaction in progress; requests ignored
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, reserved size or timeout
- rdata  output  32  read data, right-justified, unused bytes zero
- addr_bus  output  32  bus address
- data_bus  inout  32  bus data; driven only during write access, else high-Z
- rd_bus, wr_bus  output  1  bus read/write strobes
- data_mask_bus  output  4  byte enables, right-justified: 0001 byte, 0011 half, 1111 word
- fc_bus  input  1  function complete from device; only a definite 1 counts (Z/X = not complete)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: bus released (addr_bus=0, rd_bus=wr_bus=0, data_bus_mask=0, data_bus Z); busy=0. On edge with req=1: latch addr, size, wr, wdata.
  - Size 3, half at odd address or word with addr[1:0]!=0 -> DONE with error; no bus activity.
  - Otherwise -> ACCESS, timeout counter cleared.
- ACCESS: drive addr_bus, data_bus_mask, rd_bus or wr_bus; drive data_bus with wdata on writes only.
  - Edge with fc_bus=1: reads capture data_bus AND byte-mask into rdata; -> DONE, err=0.
  - Otherwise counter+1; when counter reaches TIMEOUT_CYCLES -> DONE with error, rdata unchanged.
- DONE: bus released (mandatory idle bus cycle so device completion flags clear); done=1, err per outcome; busy=1; -> IDLE next edge.
- err is 0 whenever done=0. rdata changes only on successful read completion; held otherwise.
- Counter width: 16 bits; no wrap-around possible within the legal range.

## Timing
- Reset values: busy=0, done=0, err=0, rdata=0, addr_bus=0, rd_bus=0, wr_bus=0, data_mask_bus=0, data_bus Z, state IDLE.
- rst mid-transaction: bus released immediately (asynchronously); no done pulse; latched request discarded.
- Acceptance edge E0; busy=1 from the cycle after E0.
- Read with combinational-responding device: ACCESS cycle 1, fc sampled at E1, done=1 in cycle 2.
- Write with registered-ack device: device captures at E1, fc high in cycle 2, sampled at E2, done=1 in cycle 3.
- Error from alignment/size: done=1, err=1 in cycle 1 (one cycle after E0).
- Timeout: done=1, err=1 exactly TIMEOUT_CYCLES+1 cycles after E0.
- Next request accepted earliest at the edge ending the first IDLE cycle after DONE; at least one cycle with bus released between consecutive accesses.
- req held high while busy has no effect and no queueing.

## Test plan
- Word read, addr 0x1000_0004, device returns 0xDEAD_BEEF with immediate fc -> mask 1111, rd_bus high exactly 1 cycle, done in cycle 2, rdata=0xDEAD_BEEF, err=0.
- Byte write 0x0000_00A5 to 0x1000_0001, device acks one cycle after wr -> data_mask_bus=0001, data_bus=0x0000_00A5 while wr_bus=1, done in cycle 3, data_bus Z afterwards.
- Half read at 0x1000_0003 and req_size=3 -> done+err one cycle after acceptance, rd_bus/wr_bus never asserted, rdata unchanged.
- No device (fc_bus Z), TIMEOUT_CYCLES=4 -> rd_bus high 4 cycles, done+err at cycle 5, bus released.
- Back-to-back: write then read to same device with req held high -> one released bus cycle between accesses; second request accepted only after busy=0.
- rst asserted during ACCESS -> rd_bus/wr_bus/addr_bus to 0 and data_bus Z without a clock edge; no done pulse; next request after reset completes normally.
